// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch and data access
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   if_req/if_addr            fetch request (held until if_ack)
//   if_ack/if_rdata/if_stall  fetch completion pulse, fetched word, fetch stall
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ack)
//   dm_ack/dm_rdata/dm_stall  data completion pulse, load data, data stall
//   mem_en/mem_we/mem_addr/mem_wdata  memory transaction driven from latched request
//   mem_rdata/mem_ready       memory response
//   err                       sticky timeout flag
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state;
    logic          r_own_if;
    logic [SW-1:0] r_starve_cnt;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_dm_rdata;
    logic          r_err;

    // Fetch wins when alone, or when data has already taken STARVE_MAX grants in a row over it
    logic w_pick_if;
    assign w_pick_if = if_req & (~dm_req | (r_starve_cnt == SW'(STARVE_MAX)));

    assign mem_en    = r_state == BUSY;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == DONE) & r_own_if;
    assign dm_ack    = (r_state == DONE) & ~r_own_if;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;
    assign if_stall  = if_req & ~if_ack;
    assign dm_stall  = dm_req & ~dm_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_own_if     <= 1'b0;
            r_starve_cnt <= '0;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (if_req | dm_req) begin
                    r_state  <= BUSY;
                    r_own_if <= w_pick_if;
                    r_we     <= w_pick_if ? 1'b0 : dm_we;
                    r_addr   <= w_pick_if ? if_addr : dm_addr;
                    r_wdata  <= w_pick_if ? '0 : dm_wdata;
                    r_cnt    <= '0;
                    r_starve_cnt <= (w_pick_if | ~if_req) ? '0 :
                                    (r_starve_cnt == SW'(STARVE_MAX)) ? r_starve_cnt :
                                    r_starve_cnt + SW'(1);
                end
                BUSY: if (mem_ready) begin
                    if (r_own_if)
                        r_if_rdata <= mem_rdata;
                    else if (!r_we)
                        r_dm_rdata <= mem_rdata;
                    r_state <= DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    if (r_own_if)
                        r_if_rdata <= '0;
                    else
                        r_dm_rdata <= '0;
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-timing model of the arbiter
module tb_mem_port_arbiter;
    localparam int TO = 16;
    localparam int SM = 4;

    logic        clk = 0, rst = 1;
    logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata;
    logic        if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we, err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int tests = 0, fails = 0;
    int lat = 1;
    logic stray = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a == 32'h40 ? 32'h8C010004 : {a[15:0], ~a[15:0]};
    endfunction

    // Memory: answers `lat` cycles into a transaction (lat 0 = never); `stray` drives mem_ready while idle
    assign mem_rdata = rd(mem_addr);
    initial begin
        int en_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                en_cnt++;
                mem_ready = en_cnt == lat;
            end else begin
                en_cnt = 0;
                mem_ready = stray;
            end
        end
    end

    // Model: a grant in cycle c with response delay d keeps the memory busy c+1..c+d,
    // acks in c+d+1 and can grant again from c+d+2
    initial begin
        int s = 0, en_lo = 0, ack_c = 0, free_c = 0, d;
        bit have = 0, g_if = 0, g_we = 0, g_to = 0, e_err = 0, e_en, e_ia, e_da;
        logic [31:0] g_addr = 0, g_wd = 0, g_rd = 0, e_ifrd = 0, e_dmrd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 0; s = 0; e_ifrd = 0; e_dmrd = 0; e_err = 0; free_c = cyc + 1;
            end else if (have && cyc == ack_c) begin
                if (g_to) e_err = 1;
                if (g_if) e_ifrd = g_rd;
                else if (!g_we || g_to) e_dmrd = g_rd;
            end
            e_en = have && cyc >= en_lo && cyc < ack_c;
            e_ia = have && cyc == ack_c && g_if;
            e_da = have && cyc == ack_c && !g_if;
            chk("mem_en", mem_en, e_en);
            chk("if_ack", if_ack, e_ia);
            chk("dm_ack", dm_ack, e_da);
            chk("if_rdata", if_rdata, e_ifrd);
            chk("dm_rdata", dm_rdata, e_dmrd);
            chk("err", err, e_err);
            chk("if_stall", if_stall, if_req & ~e_ia);
            chk("dm_stall", dm_stall, dm_req & ~e_da);
            if (e_en) begin
                chk("mem_we", mem_we, g_we);
                chk("mem_addr", mem_addr, g_addr);
                chk("mem_wdata", mem_wdata, g_wd);
            end
            if (!rst && cyc >= free_c && (if_req || dm_req)) begin
                g_if   = if_req && (!dm_req || s == SM);
                s      = (g_if || !if_req) ? 0 : (s < SM ? s + 1 : SM);
                g_we   = g_if ? 1'b0 : dm_we;
                g_addr = g_if ? if_addr : dm_addr;
                g_wd   = g_if ? 32'h0 : dm_wdata;
                g_to   = !(lat >= 1 && lat <= TO);
                d      = g_to ? TO : lat;
                g_rd   = g_to ? 32'h0 : rd(g_addr);
                en_lo  = cyc + 1;
                ack_c  = cyc + d + 1;
                free_c = ack_c + 1;
                have   = 1;
            end
        end
    end

    task automatic wait_ack(input bit want_if, input string nm, output int at);
        at = -1;
        for (int n = 0; n < 40 && at < 0; n++) begin
            @(negedge clk);
            if (want_if ? if_ack : dm_ack) at = cyc;
        end
        chk({nm, "_ack_seen"}, at >= 0, 1);
    endtask

    task automatic dm_op(input bit we, input logic [31:0] a, input logic [31:0] wd, input int l,
                         output int t_req, output int t_ack);
        @(posedge clk);
        #1;
        lat = l; dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd; t_req = cyc;
        wait_ack(0, "dm", t_ack);
        @(posedge clk);
        #1;
        dm_req = 0;
    endtask

    initial begin
        int t, ta, ti, td, if_at;
        int dm_at[5];
        int n_before;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_err", err, 0);
        rst = 0;

        // Single fetch with one-cycle memory latency
        @(posedge clk);
        #1;
        lat = 1; if_req = 1; if_addr = 32'h40; t = cyc;
        @(negedge clk);
        chk("fetch_en_t", mem_en, 0);
        @(negedge clk);
        chk("fetch_en_t1", mem_en, 1);
        @(negedge clk);
        chk("fetch_ack_t2", if_ack, 1);
        chk("fetch_rdata", if_rdata, 32'h8C010004);
        chk("fetch_no_dm_ack", dm_ack, 0);
        @(posedge clk);
        #1;
        if_req = 0;

        // Simultaneous requests: store wins, fetch follows
        @(posedge clk);
        #1;
        if_req = 1; if_addr = 32'h44;
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hAB;
        @(negedge clk);
        @(negedge clk);
        chk("sim_first_we", mem_we, 1);
        chk("sim_first_addr", mem_addr, 32'h100);
        wait_ack(0, "sim_dm", td);
        @(posedge clk);
        #1;
        dm_req = 0;
        wait_ack(1, "sim_if", ti);
        chk("sim_if_after_dm", ti > td, 1);
        @(posedge clk);
        #1;
        if_req = 0;

        // Starvation: fetch held against five back-to-back loads
        @(posedge clk);
        #1;
        fork
            begin
                if_req = 1; if_addr = 32'h48;
                wait_ack(1, "starve_if", if_at);
                chk("starve_cnt_clear", dut.r_starve_cnt, 0);
                @(posedge clk);
                #1;
                if_req = 0;
            end
            begin
                dm_req = 1; dm_we = 0;
                for (int i = 0; i < 5; i++) begin
                    dm_addr = 32'h200 + 32'(i * 4);
                    wait_ack(0, "starve_dm", dm_at[i]);
                    @(posedge clk);
                    #1;
                end
                dm_req = 0;
            end
        join
        n_before = 0;
        for (int i = 0; i < 5; i++) if (dm_at[i] < if_at) n_before++;
        chk("starve_dm_before_if", n_before, 4);

        // mem_ready on the last allowed cycle beats the timeout
        dm_op(0, 32'h10, 0, 16, t, ta);
        chk("lat16_latency", ta - t, 17);
        chk("lat16_no_err", err, 0);

        // Store with 5-cycle latency; load data must be untouched
        dm_op(1, 32'h180, 32'h12345678, 5, t, ta);
        chk("lat5_latency", ta - t, 6);
        chk("store_keeps_rdata", dm_rdata, 32'h0010FFEF);

        // Stray mem_ready around an idle-to-busy transition is ignored
        stray = 1;
        repeat (3) @(posedge clk);
        dm_op(0, 32'h24, 0, 3, t, ta);
        chk("stray_latency", ta - t, 4);
        stray = 0;

        // Timeout on a load
        dm_op(0, 32'h200, 0, 0, t, ta);
        chk("to_latency", ta - t, 17);
        chk("to_rdata", dm_rdata, 0);
        chk("to_err", err, 1);
        dm_op(0, 32'h300, 0, 2, t, ta);
        chk("post_to_latency", ta - t, 3);
        chk("post_to_rdata", dm_rdata, 32'h0300FCFF);
        chk("err_sticky", err, 1);

        // Asynchronous reset two cycles into a fetch
        @(posedge clk);
        #1;
        lat = 8; if_req = 1; if_addr = 32'h50;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("arst_mem_en", mem_en, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_if_rdata", if_rdata, 0);
        chk("arst_dm_rdata", dm_rdata, 0);
        chk("arst_err", err, 0);
        chk("arst_if_ack", if_ack, 0);
        @(posedge clk);
        #1;
        if_req = 0;
        @(posedge clk);
        #1;
        rst = 0;
        dm_op(0, 32'h20, 0, 1, t, ta);
        chk("post_rst_latency", ta - t, 2);
        chk("post_rst_rdata", dm_rdata, 32'h0020FFDF);
        chk("post_rst_err", err, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline. It grants one requester at a time, gives data requests priority with a starvation guard for fetch, and holds each memory transaction until the memory answers or a timeout fires. It sits between the PC/IF-ID logic and the EX-MEM/MEM-WB logic, and its stall outputs feed the hazard path.

## Interface
- STARVE_MAX, 4: consecutive DM grants allowed while a fetch is pending before IF is forced.
- TIMEOUT, 16: maximum BUSY cycles waiting for mem_ready before an error completion.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetched instruction; valid with if_ack, held until the next fetch completion.
- if_stall  out  1  if_req & ~if_ack.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle completion pulse for data.
- dm_rdata  out  32  load data; valid with dm_ack, held until the next DM load completion.
- dm_stall  out  1  dm_req & ~dm_ack.
- mem_en  out  1  memory transaction active.
- mem_we  out  1  write strobe; meaningful only when mem_en = 1.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  memory completion; sampled only while mem_en = 1.
- err  out  1  sticky timeout flag; cleared only by rst.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE with no request: stay in IDLE.
- IDLE with any request, winner selection:
  - dm_req alone wins for DM.
  - if_req alone wins for IF.
  - If both are asserted, DM wins unless starve_cnt == STARVE_MAX; then IF wins.
- On a grant:
  - Latch owner, address, we (IF forces we = 0) and wdata into registers.
  - Go to BUSY and clear the BUSY cycle counter.
- starve_cnt (width ceil(log2(STARVE_MAX+1)), reset 0):
  - Increments on a DM grant while if_req = 1.
  - Clears on an IF grant.
  - Clears on a DM grant with if_req = 0.
  - Saturates at STARVE_MAX.
- BUSY:
  - mem_en = 1. mem_we, mem_addr and mem_wdata are driven from the latched registers and stay stable for the whole state.
  - On mem_ready = 1: for a load or fetch, capture mem_rdata into the owner's rdata register (stores leave dm_rdata unchanged). Then go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT - 1 without mem_ready: capture 32'h0 as the owner's read data, set err, and go to DONE.
- DONE:
  - mem_en = 0.
  - The owner's ack = 1 for exactly this cycle.
  - Next state is IDLE unconditionally; no grant is made in DONE.
- Requester rule: after sampling ack, the requester drops req or presents a new request in the following cycle. The arbiter never re-grants on the ack cycle.
- if_stall and dm_stall are combinational. All other outputs are registered or decoded from registered state.

## Timing
- Reset values:
  - state IDLE, starve_cnt 0, counter 0.
  - mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - if_ack 0, dm_ack 0, if_rdata 0, dm_rdata 0, err 0.
- rst asserted mid-transaction: mem_en drops immediately (asynchronously), no ack is issued, and the latched request is discarded.
- Request sampled in IDLE at cycle t:
  - mem_en is high from t+1.
  - If mem_ready first arrives in cycle t+k (k ≥ 1), ack is high in cycle t+k+1.
  - Minimum req-to-ack latency is 2 cycles. Minimum back-to-back spacing is 3 cycles per transaction.
- mem_ready while mem_en = 0 is ignored.
- Timeout: with no mem_ready, ack is high in cycle t+TIMEOUT+1.
- Simultaneous mem_ready and the timeout edge: mem_ready wins, and err stays unchanged.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x40, memory returns 0x8C010004 with 1-cycle latency → mem_en high in t+1, if_ack pulse in t+2, if_rdata = 0x8C010004, dm_ack stays 0.
- Simultaneous requests: if_req and dm_req both high at t, dm_we = 1, dm_addr = 0x100, dm_wdata = 0xAB → first mem_en has mem_we = 1 and mem_addr = 0x100; dm_ack follows. The fetch is granted in the next IDLE and its if_ack arrives after that.
- Starvation: hold if_req and issue five back-to-back DM loads (immediate mem_ready) → four DM grants, then an IF grant on the fifth arbitration, then starve_cnt = 0.
- Timeout: dm_req load, mem_ready held 0 → dm_ack exactly 17 cycles after the request cycle, dm_rdata = 0, err = 1, and err persists through later good transactions.
- Async reset mid-BUSY: assert rst two cycles into a fetch → mem_en falls without a clock edge, no if_ack, all outputs at reset values. After rst is released, a new DM request completes normally.
- Variable latency and stability: mem_ready delayed by 5 cycles → mem_addr and mem_we stay constant through all 5 cycles, and the ack comes 1 cycle after mem_ready.
